// File: rtl/ex_operand_stage.sv
// Operand-resolve pipeline register in front of the ALU. It holds one decoded
// instruction and keeps re-resolving its sources from the MEM and WB forwarding ports.
module ex_operand_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rs1_addr,
    input  logic [4:0]      in_rs2_addr,
    input  logic [4:0]      in_rd_addr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_pc,
    input  logic            in_use_imm,
    input  logic            in_use_pc,
    input  logic [3:0]      in_alu_sel,
    input  logic            mem_fwd_valid,
    input  logic [4:0]      mem_fwd_rd,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic            mem_fwd_pending,
    input  logic            wb_fwd_valid,
    input  logic [4:0]      wb_fwd_rd,
    input  logic [XLEN-1:0] wb_fwd_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_sel,
    output logic [4:0]      out_rd
);

    logic            full_reg, full_next;
    logic [4:0]      rd_reg;
    logic [3:0]      alu_sel_reg;
    logic            use_imm_reg;
    logic            use_pc_reg;
    logic [XLEN-1:0] imm_reg;
    logic [XLEN-1:0] pc_reg;

    // Index 0 is rs1, index 1 is rs2.
    logic [4:0]      addr_reg  [2];
    logic [XLEN-1:0] val_reg   [2];
    logic            pend_reg  [2];
    logic [XLEN-1:0] val_next  [2];
    logic            pend_next [2];

    logic [4:0]      in_addr   [2];
    logic [XLEN-1:0] in_data   [2];
    logic [4:0]      src_addr  [2];
    logic [XLEN-1:0] base_val  [2];
    logic            base_pend [2];
    logic            mem_match [2];
    logic            wb_match  [2];

    logic capture;
    logic consume;
    logic rs1_used;
    logic rs2_used;

    assign in_addr[0] = in_rs1_addr;
    assign in_addr[1] = in_rs2_addr;
    assign in_data[0] = in_rs1_data;
    assign in_data[1] = in_rs2_data;

    assign rs1_used  = !use_pc_reg;
    assign rs2_used  = !use_imm_reg;
    assign out_valid = full_reg && !(rs1_used && pend_reg[0]) && !(rs2_used && pend_reg[1]);
    assign consume   = out_valid && out_ready;
    assign in_ready  = !full_reg || consume;
    assign capture   = in_valid && in_ready;

    // The same resolve runs on a freshly captured operand (base = register-file data)
    // and on a held one (base = current value), so a stalled entry never misses a forward.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            assign src_addr[gi]  = capture ? in_addr[gi] : addr_reg[gi];
            assign base_val[gi]  = capture ? in_data[gi] : val_reg[gi];
            assign base_pend[gi] = capture ? 1'b0 : pend_reg[gi];

            assign mem_match[gi] = mem_fwd_valid && (mem_fwd_rd == src_addr[gi]) && (src_addr[gi] != 5'd0);
            assign wb_match[gi]  = wb_fwd_valid && (wb_fwd_rd == src_addr[gi]) && (src_addr[gi] != 5'd0);

            assign val_next[gi]  = mem_match[gi] ? (mem_fwd_pending ? base_val[gi] : mem_fwd_data)
                                 : wb_match[gi]  ? wb_fwd_data
                                 :                 base_val[gi];
            assign pend_next[gi] = mem_match[gi] ? mem_fwd_pending
                                 : wb_match[gi]  ? 1'b0
                                 :                 base_pend[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    addr_reg[gi] <= '0;
                    val_reg[gi]  <= '0;
                    pend_reg[gi] <= 1'b0;
                end else begin
                    if (capture) begin
                        addr_reg[gi] <= in_addr[gi];
                    end
                    val_reg[gi]  <= val_next[gi];
                    pend_reg[gi] <= pend_next[gi];
                end
            end
        end
    endgenerate

    // Flush wins over both capture and consume.
    always_comb begin
        full_next = full_reg;
        if (flush) begin
            full_next = 1'b0;
        end else if (capture) begin
            full_next = 1'b1;
        end else if (consume) begin
            full_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_reg    <= 1'b0;
            rd_reg      <= '0;
            alu_sel_reg <= '0;
            use_imm_reg <= 1'b0;
            use_pc_reg  <= 1'b0;
            imm_reg     <= '0;
            pc_reg      <= '0;
        end else begin
            full_reg <= full_next;
            if (capture) begin
                rd_reg      <= in_rd_addr;
                alu_sel_reg <= in_alu_sel;
                use_imm_reg <= in_use_imm;
                use_pc_reg  <= in_use_pc;
                imm_reg     <= in_imm;
                pc_reg      <= in_pc;
            end
        end
    end

    assign alu_a   = use_pc_reg  ? pc_reg  : val_reg[0];
    assign alu_b   = use_imm_reg ? imm_reg : val_reg[1];
    assign alu_sel = alu_sel_reg;
    assign out_rd  = rd_reg;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: hazards, forwarding priority, backpressure,
// flush and asynchronous reset, each against hand-computed values.
module tb_ex_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
    logic        in_use_imm, in_use_pc;
    logic [3:0]  in_alu_sel;
    logic        mem_fwd_valid;
    logic [4:0]  mem_fwd_rd;
    logic [31:0] mem_fwd_data;
    logic        mem_fwd_pending;
    logic        wb_fwd_valid;
    logic [4:0]  wb_fwd_rd;
    logic [31:0] wb_fwd_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_sel;
    logic [4:0]  out_rd;

    int checks;
    int failures;

    ex_operand_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_pc(in_pc),
        .in_use_imm(in_use_imm), .in_use_pc(in_use_pc), .in_alu_sel(in_alu_sel),
        .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd),
        .mem_fwd_data(mem_fwd_data), .mem_fwd_pending(mem_fwd_pending),
        .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .out_rd(out_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [4:0] rs1, input logic [31:0] d1,
                           input logic [4:0] rs2, input logic [31:0] d2,
                           input logic [4:0] rd, input logic [3:0] sel);
        in_valid    = 1'b1;
        in_rs1_addr = rs1;
        in_rs1_data = d1;
        in_rs2_addr = rs2;
        in_rs2_data = d2;
        in_rd_addr  = rd;
        in_alu_sel  = sel;
        in_use_imm  = 1'b0;
        in_use_pc   = 1'b0;
        in_imm      = 32'h0;
        in_pc       = 32'h0;
    endtask

    task automatic clear_fwd();
        mem_fwd_valid   = 1'b0;
        mem_fwd_rd      = 5'd0;
        mem_fwd_data    = 32'h0;
        mem_fwd_pending = 1'b0;
        wb_fwd_valid    = 1'b0;
        wb_fwd_rd       = 5'd0;
        wb_fwd_data     = 32'h0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        out_ready = 1'b0;
        present(5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 4'h0);
        in_valid = 1'b0;
        clear_fwd();

        // Reset state
        #2;
        check_val("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_val("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check_val("rst_alu_a", alu_a, 32'h0);
        check_val("rst_alu_b", alu_b, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // No hazard
        present(5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 4'b0000);
        step();
        in_valid = 1'b0;
        check_val("nohaz_valid", {31'b0, out_valid}, 32'd1);
        check_val("nohaz_a", alu_a, 32'd5);
        check_val("nohaz_b", alu_b, 32'd7);
        check_val("nohaz_rd", {27'b0, out_rd}, 32'd3);
        out_ready = 1'b1;
        #1;
        check_val("nohaz_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        check_val("nohaz_drained", {31'b0, out_valid}, 32'd0);

        // MEM beats WB for the same register
        present(5'd1, 32'h55, 5'd0, 32'h0, 5'd4, 4'b0101);
        mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd1; mem_fwd_data = 32'h10;
        wb_fwd_valid  = 1'b1; wb_fwd_rd  = 5'd1; wb_fwd_data  = 32'h20;
        step();
        clear_fwd();
        check_val("prio_a", alu_a, 32'h10);
        check_val("prio_b", alu_b, 32'h0);
        check_val("prio_sel", {28'b0, alu_sel}, 32'h5);

        // x0 never forwards; back-to-back replacement of the previous entry
        present(5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 4'b0001);
        mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'hFFFF;
        wb_fwd_valid  = 1'b1; wb_fwd_rd  = 5'd0; wb_fwd_data  = 32'hFFFF;
        step();
        clear_fwd();
        in_valid = 1'b0;
        check_val("x0_valid", {31'b0, out_valid}, 32'd1);
        check_val("x0_a", alu_a, 32'h0);
        check_val("x0_sel", {28'b0, alu_sel}, 32'h1);
        step();

        // Load-use on rs2, resolved later by WB
        present(5'd1, 32'd1, 5'd2, 32'd2, 5'd5, 4'b0010);
        mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd2; mem_fwd_data = 32'hDEAD; mem_fwd_pending = 1'b1;
        step();
        clear_fwd();
        in_valid = 1'b0;
        check_val("lu_stall_valid", {31'b0, out_valid}, 32'd0);
        check_val("lu_stall_in_ready", {31'b0, in_ready}, 32'd0);
        wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd2; wb_fwd_data = 32'hABCD;
        step();
        clear_fwd();
        check_val("lu_resolved_valid", {31'b0, out_valid}, 32'd1);
        check_val("lu_resolved_b", alu_b, 32'hABCD);

        // Same hazard with an immediate B operand: no stall
        present(5'd1, 32'd1, 5'd2, 32'd2, 5'd6, 4'b0011);
        in_use_imm = 1'b1; in_imm = 32'd4;
        mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd2; mem_fwd_data = 32'hDEAD; mem_fwd_pending = 1'b1;
        step();
        clear_fwd();
        in_valid = 1'b0;
        check_val("imm_valid", {31'b0, out_valid}, 32'd1);
        check_val("imm_b", alu_b, 32'd4);
        step();

        // Backpressure with a WB refresh of rs1 while held
        out_ready = 1'b0;
        present(5'd5, 32'h11, 5'd6, 32'h22, 5'd7, 4'b0100);
        step();
        present(5'd8, 32'h33, 5'd9, 32'h44, 5'd10, 4'b0110);
        check_val("bp_in_ready", {31'b0, in_ready}, 32'd0);
        check_val("bp_valid", {31'b0, out_valid}, 32'd1);
        wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd5; wb_fwd_data = 32'h99;
        step();
        clear_fwd();
        check_val("bp_refresh_a", alu_a, 32'h99);
        check_val("bp_hold_b", alu_b, 32'h22);
        check_val("bp_hold_rd", {27'b0, out_rd}, 32'd7);
        step();
        check_val("bp_stable_a", alu_a, 32'h99);
        check_val("bp_stable_in_ready", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1;
        check_val("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        check_val("bp_next_a", alu_a, 32'h33);
        check_val("bp_next_b", alu_b, 32'h44);
        check_val("bp_next_rd", {27'b0, out_rd}, 32'd10);

        // Flush kills held entry and same-cycle capture
        present(5'd11, 32'h66, 5'd12, 32'h77, 5'd13, 4'b0111);
        flush = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        check_val("flush_valid", {31'b0, out_valid}, 32'd0);
        check_val("flush_in_ready", {31'b0, in_ready}, 32'd1);

        // Asynchronous reset while stalled on a pending operand
        present(5'd1, 32'h1, 5'd2, 32'h2, 5'd14, 4'b1000);
        mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd1; mem_fwd_data = 32'h0; mem_fwd_pending = 1'b1;
        step();
        in_valid = 1'b0;
        check_val("rst2_stalled", {31'b0, out_valid}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst2_valid", {31'b0, out_valid}, 32'd0);
        check_val("rst2_in_ready", {31'b0, in_ready}, 32'd1);
        check_val("rst2_a", alu_a, 32'h0);
        check_val("rst2_sel", {28'b0, alu_sel}, 32'h0);
        check_val("rst2_rd", {27'b0, out_rd}, 32'h0);
        clear_fwd();
        #1;
        rst_n = 1'b1;
        present(5'd1, 32'h77, 5'd2, 32'h88, 5'd15, 4'b1001);
        step();
        in_valid = 1'b0;
        check_val("post_rst_valid", {31'b0, out_valid}, 32'd1);
        check_val("post_rst_a", alu_a, 32'h77);
        check_val("post_rst_rd", {27'b0, out_rd}, 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

Pipeline register directly upstream of the 32-bit ALU: accepts a decoded instruction from the decode stage and resolves its source operands. Operands come from register-file read data, immediate or PC, plus two forwarding sources (MEM and WB). It holds the instruction until both ALU operands are valid, then presents `alu_a`, `alu_b` and `alu_sel` to the ALU under a valid/ready handshake. It is a one-entry stage that also refreshes held operands while stalled, so forwarded results are never missed.

## Interface
- `XLEN`, 32: operand width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: decode presents an instruction.
- `in_ready` out 1: stage accepts this cycle.
- `in_rs1_addr`, `in_rs2_addr`, `in_rd_addr` in 5 each: register indices.
- `in_rs1_data`, `in_rs2_data` in XLEN each: register-file read data.
- `in_imm`, `in_pc` in XLEN each: immediate and PC.
- `in_use_imm` in 1: B operand is `in_imm`, not rs2.
- `in_use_pc` in 1: A operand is `in_pc`, not rs1.
- `in_alu_sel` in 4: ALU operation code, passed through.
- `mem_fwd_valid` in 1: MEM stage writes `mem_fwd_rd`.
- `mem_fwd_rd` in 5: MEM destination.
- `mem_fwd_data` in XLEN: MEM result.
- `mem_fwd_pending` in 1: MEM result not yet available (load).
- `wb_fwd_valid` in 1: WB stage writes `wb_fwd_rd`.
- `wb_fwd_rd` in 5: WB destination.
- `wb_fwd_data` in XLEN: WB result.
- `flush` in 1: synchronous kill of held and incoming instruction.
- `out_valid` out 1: ALU operands valid.
- `out_ready` in 1: downstream consumes.
- `alu_a`, `alu_b` out XLEN each: ALU operands.
- `alu_sel` out 4: ALU operation code.
- `out_rd` out 5: destination, forwarded with result.

## Operation
- State: `full`, `rd`, `alu_sel`, `use_imm`, `use_pc`, `imm`, `pc`, `rs1_addr`, `rs2_addr`, `rs1_val`, `rs2_val`, `rs1_pend`, `rs2_pend`.
- Forward match for operand with address r:
  - MEM match: `mem_fwd_valid && mem_fwd_rd==r && r!=0`.
  - WB match: `wb_fwd_valid && wb_fwd_rd==r && r!=0`.
  - MEM has priority over WB (younger). Index 0 never forwards; its value is the register-file data, which is always 0.
- Operand resolve, applied identically at capture and on every held cycle:
  - MEM match and `mem_fwd_pending`: set pend.
  - MEM match and not pending: val=`mem_fwd_data`, clear pend.
  - Else WB match: val=`wb_fwd_data`, clear pend.
  - Else at capture: val=`in_rsX_data`, pend=0. Held cycle: unchanged.
- Capture: `in_valid && in_ready` loads all fields from `in_*`, then resolves.
- Pending is only significant for used operands:
  - rs1 used iff `!use_pc`.
  - rs2 used iff `!use_imm`.
- Output selects:
  - `alu_a = use_pc ? pc : rs1_val`.
  - `alu_b = use_imm ? imm : rs2_val`.
  - `alu_sel`, `out_rd` straight from registers.
- `out_valid = full && !(rs1 used && rs1_pend) && !(rs2 used && rs2_pend)`.
- `in_ready = !full || (out_valid && out_ready)`, combinational.
- Entry update:
  - Consumed without capture: `full` clears.
  - Consumed and capture in the same cycle: back-to-back replacement.
- `flush` has top priority: `full`←0 and any same-cycle capture is discarded. `in_ready` is unaffected by `flush`.

## Timing
- Capture-to-`out_valid`: 1 cycle when no pending operand.
- Each pending operand adds cycles until the producer's data appears on a non-pending MEM or WB port. `out_valid` rises the cycle after that port is sampled.
- Full throughput: one instruction per cycle while `out_ready`=1 and no pending operands.
- Reset (async, `rst_n`=0):
  - Clears `full`, all pend flags and all data registers.
  - Outputs: `out_valid`=0, `alu_a`=`alu_b`=0, `alu_sel`=0, `out_rd`=0, `in_ready`=1.
- Reset mid-stall discards the held instruction. The first accept is possible on the first edge after `rst_n` rises.
- `out_valid` high with `out_ready` low: outputs hold stable. Refresh cannot change a used, already-valid operand except by a newer forward to the same register.

## Test plan
- No hazard: capture rs1=x1 (data 5), rs2=x2 (data 7), `alu_sel`=0000 -> next cycle `out_valid`=1, `alu_a`=5, `alu_b`=7.
- MEM vs WB priority: at capture, MEM writes x1=0x10 and WB writes x1=0x20 -> `alu_a`=0x10. Also, rd=x0 forwarding 0xFFFF to rs1=x0 -> `alu_a`=0.
- Load-use: at capture, MEM matches x2 with `mem_fwd_pending`=1 -> `out_valid`=0. Next cycle, WB presents x2=0xABCD -> one cycle later `out_valid`=1, `alu_b`=0xABCD. With `in_use_imm`=1 and imm=4, the same hazard gives no stall and `alu_b`=4.
- Backpressure: `out_ready`=0 for 3 cycles with entry valid -> `in_ready`=0 and outputs stable. Meanwhile WB writes rs1 reg 0x99 -> `alu_a` updates to 0x99. On `out_ready`=1, a new instruction captures in the same cycle.
- Flush: `flush`=1 while entry held and `in_valid`=1 -> next cycle `out_valid`=0, stage empty.
- Reset: `rst_n` low while stalled with pend set -> all outputs 0 asynchronously, `in_ready`=1.
